// File: rtl/enc_spawn_scheduler_if.sv
// Handshake bundle between the encounter spawn scheduler and its surroundings.
// The scheduler takes the slave view; the driver of frame_start/hit takes the master view.
interface enc_spawn_scheduler_if;
    logic       frame_start;
    logic       hit;
    logic       spawn_enc1;
    logic       spawn_enc2;
    logic       spawn_enc3;
    logic [2:0] lane_busy;
    logic [7:0] spawn_total;

    modport master (
        output frame_start,
        output hit,
        input  spawn_enc1,
        input  spawn_enc2,
        input  spawn_enc3,
        input  lane_busy,
        input  spawn_total
    );

    modport slave (
        input  frame_start,
        input  hit,
        output spawn_enc1,
        output spawn_enc2,
        output spawn_enc3,
        output lane_busy,
        output spawn_total
    );
endinterface

// File: rtl/enc_spawn_scheduler.sv
// Encounter spawn scheduler: decides, frame by frame, when and in which of the
// three lanes a new encounter appears. A free-running 16-bit Fibonacci LFSR
// supplies lane choice and gap jitter; every lane is blocked for LANE_HOLD
// frames after it spawns. A hit freezes everything until reset.
module enc_spawn_scheduler #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned MIN_GAP       = 30,
    parameter int unsigned GAP_RAND_BITS = 5,
    parameter int unsigned LANE_HOLD     = 90
) (
    input  logic                 clock,
    input  logic                 reset_n,
    enc_spawn_scheduler_if.slave bus
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int unsigned MASK_INT  = (32'd1 << GAP_RAND_BITS) - 32'd1;
    localparam logic [7:0]  RAND_MASK = MASK_INT[7:0];
    localparam logic [9:0]  GAP_BASE  = MIN_GAP[9:0];
    localparam logic [7:0]  HOLD_LOAD = LANE_HOLD[7:0];

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_PICK,
        ST_FIRE,
        ST_HALT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     lfsr;
    logic            lfsr_fb;
    logic [9:0]      gap;
    logic [2:0][7:0] hold;
    logic [1:0]      lane_sel;
    logic [2:0]      spawn;
    logic [7:0]      total;
    logic            active;

    logic [1:0]      cand;
    logic [1:0]      probe [3];
    logic            probe_free;
    logic            pick_found;
    logic [1:0]      pick_lane;

    // Feedback taps and the "still running" qualifier; hit blocks the update on the same edge.
    always_comb begin
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        active  = (state != ST_HALT) && !bus.hit;
    end

    // Lane search: start at the random candidate, walk cand, cand+1, cand+2 (mod 3).
    always_comb begin
        cand       = (lfsr[1:0] == 2'd3) ? {1'b0, lfsr[2]} : lfsr[1:0];
        probe[0]   = cand;
        probe[1]   = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        probe[2]   = (cand == 2'd0) ? 2'd2 : cand - 2'd1;
        pick_found = 1'b0;
        pick_lane  = 2'd0;
        probe_free = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            case (probe[k])
                2'd0:    probe_free = (hold[0] == 8'd0);
                2'd1:    probe_free = (hold[1] == 8'd0);
                2'd2:    probe_free = (hold[2] == 8'd0);
                default: probe_free = 1'b0;
            endcase
            if (!pick_found && probe_free) begin
                pick_found = 1'b1;
                pick_lane  = probe[k];
            end
        end
    end

    // Next-state logic; hit overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (bus.frame_start && gap <= 10'd1) state_nxt = ST_PICK;
            ST_PICK: state_nxt = pick_found ? ST_FIRE : ST_WAIT;
            ST_FIRE: state_nxt = ST_WAIT;
            default: state_nxt = ST_HALT;
        endcase
        if (bus.hit) state_nxt = ST_HALT;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_WAIT;
        else          state <= state_nxt;
    end

    // Datapath: LFSR, gap counter, lane holds, spawn pulse and spawn count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr     <= SEED_EFF;
            gap      <= GAP_BASE;
            hold     <= '0;
            lane_sel <= '0;
            spawn    <= '0;
            total    <= '0;
        end else begin
            spawn <= '0;
            if (active) begin
                lfsr <= {lfsr[14:0], lfsr_fb};
                // The FIRE load of a lane takes precedence over its frame decrement.
                for (int unsigned i = 0; i < 3; i++) begin
                    if (state == ST_FIRE && lane_sel == i[1:0]) begin
                        hold[i]  <= HOLD_LOAD;
                        spawn[i] <= 1'b1;
                    end else if (bus.frame_start && hold[i] != 8'd0) begin
                        hold[i] <= hold[i] - 8'd1;
                    end
                end
                case (state)
                    ST_WAIT: begin
                        if (bus.frame_start) gap <= (gap > 10'd1) ? gap - 10'd1 : '0;
                    end
                    ST_PICK: begin
                        if (pick_found) lane_sel <= pick_lane;
                        else            gap      <= 10'd1;
                    end
                    ST_FIRE: begin
                        gap <= GAP_BASE + {2'b00, lfsr[7:0] & RAND_MASK};
                        if (total != 8'hFF) total <= total + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.spawn_enc1  = spawn[0];
    assign bus.spawn_enc2  = spawn[1];
    assign bus.spawn_enc3  = spawn[2];
    assign bus.lane_busy   = {|hold[2], |hold[1], |hold[0]};
    assign bus.spawn_total = total;

endmodule

// File: tb/tb_enc_spawn_scheduler.sv
// Self-checking bench for enc_spawn_scheduler: four differently parameterised
// instances share clock, reset and frame_start; each has its own hit line.
module tb_enc_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fs;
    logic [3:0] hit_v;

    always #5 clk = ~clk;

    enc_spawn_scheduler_if bus0();
    enc_spawn_scheduler_if bus1();
    enc_spawn_scheduler_if bus2();
    enc_spawn_scheduler_if bus3();

    assign bus0.frame_start = fs;
    assign bus1.frame_start = fs;
    assign bus2.frame_start = fs;
    assign bus3.frame_start = fs;
    assign bus0.hit = hit_v[0];
    assign bus1.hit = hit_v[1];
    assign bus2.hit = hit_v[2];
    assign bus3.hit = hit_v[3];

    enc_spawn_scheduler #(.MIN_GAP(2), .GAP_RAND_BITS(0), .LANE_HOLD(1)) dut0 (
        .clock(clk), .reset_n(rst_n), .bus(bus0));
    enc_spawn_scheduler #(.MIN_GAP(1), .GAP_RAND_BITS(0), .LANE_HOLD(100)) dut1 (
        .clock(clk), .reset_n(rst_n), .bus(bus1));
    enc_spawn_scheduler #(.MIN_GAP(1), .GAP_RAND_BITS(0), .LANE_HOLD(1)) dut2 (
        .clock(clk), .reset_n(rst_n), .bus(bus2));
    enc_spawn_scheduler #(.MIN_GAP(30), .GAP_RAND_BITS(3), .LANE_HOLD(90)) dut3 (
        .clock(clk), .reset_n(rst_n), .bus(bus3));

    logic [2:0] sp  [4];
    logic [2:0] lb  [4];
    logic [7:0] tot [4];

    assign sp[0]  = {bus0.spawn_enc3, bus0.spawn_enc2, bus0.spawn_enc1};
    assign sp[1]  = {bus1.spawn_enc3, bus1.spawn_enc2, bus1.spawn_enc1};
    assign sp[2]  = {bus2.spawn_enc3, bus2.spawn_enc2, bus2.spawn_enc1};
    assign sp[3]  = {bus3.spawn_enc3, bus3.spawn_enc2, bus3.spawn_enc1};
    assign lb[0]  = bus0.lane_busy;
    assign lb[1]  = bus1.lane_busy;
    assign lb[2]  = bus2.lane_busy;
    assign lb[3]  = bus3.lane_busy;
    assign tot[0] = bus0.spawn_total;
    assign tot[1] = bus1.spawn_total;
    assign tot[2] = bus2.spawn_total;
    assign tot[3] = bus3.spawn_total;

    // Reference model parameters, one entry per instance.
    int MG [4] = '{2, 1, 1, 30};
    int RB [4] = '{0, 0, 0, 3};
    int LH [4] = '{1, 100, 1, 90};

    // Reference model state: plain integers, events scheduled by absolute edge number.
    logic [15:0] m_lf      [4];
    int          m_gap     [4];
    int          m_hold    [4][3];
    int          m_total   [4];
    bit          m_halt    [4];
    longint      m_pick_at [4];
    longint      m_fire_at [4];
    int          m_lane    [4];
    int          m_pulse   [4];
    longint      cyc;

    int n_tests;
    int n_fail;
    int frame_no;
    int last_pulse;
    int pulses_after_hit;

    typedef struct {
        int frames;
        int t0;
        int t1;
        int b1;
        int t2;
    } vec_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset_one(input int i);
        m_lf[i]      = 16'hACE1;
        m_gap[i]     = MG[i];
        for (int l = 0; l < 3; l++) m_hold[i][l] = 0;
        m_total[i]   = 0;
        m_halt[i]    = 1'b0;
        m_pick_at[i] = -1;
        m_fire_at[i] = -1;
        m_lane[i]    = 0;
        m_pulse[i]   = -1;
    endtask

    task automatic model_reset_all();
        for (int i = 0; i < 4; i++) model_reset_one(i);
    endtask

    // One rising edge of instance i, seen as: frame counting, a lane choice one
    // edge after the qualifying frame, and the spawn one edge after that.
    task automatic model_edge(input int i, input bit f, input bit h);
        int  loaded;
        int  cand;
        int  ln;
        int  mask;
        bit  engaged;
        m_pulse[i] = -1;
        if (m_halt[i] || h) begin
            m_halt[i] = 1'b1;
            return;
        end
        engaged = (cyc == m_pick_at[i]) || (cyc == m_fire_at[i]);
        loaded  = -1;
        if (cyc == m_fire_at[i]) begin
            ln            = m_lane[i];
            m_pulse[i]    = ln;
            loaded        = ln;
            m_hold[i][ln] = LH[i];
            mask          = (1 << RB[i]) - 1;
            m_gap[i]      = MG[i] + (int'(m_lf[i][7:0]) & mask);
            if (m_total[i] < 255) m_total[i]++;
            m_fire_at[i]  = -1;
        end
        if (cyc == m_pick_at[i]) begin
            cand = int'(m_lf[i][1:0]);
            if (cand == 3) cand = int'(m_lf[i][2]);
            ln = -1;
            for (int k = 0; k < 3; k++)
                if (ln < 0 && m_hold[i][(cand + k) % 3] == 0) ln = (cand + k) % 3;
            if (ln >= 0) begin
                m_lane[i]    = ln;
                m_fire_at[i] = cyc + 1;
            end else begin
                m_gap[i] = 1;
            end
            m_pick_at[i] = -1;
        end
        if (f) begin
            for (int l = 0; l < 3; l++)
                if (l != loaded && m_hold[i][l] > 0) m_hold[i][l]--;
            if (!engaged) begin
                if (m_gap[i] > 1) begin
                    m_gap[i]--;
                end else begin
                    m_gap[i]     = 0;
                    m_pick_at[i] = cyc + 1;
                end
            end
        end
        m_lf[i] = lfsr_next(m_lf[i]);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (frame %0d)", name, act, exp, frame_no);
        end
    endtask

    // Advance one clock, step the models, then compare every instance against its model.
    task automatic tick();
        int e_sp;
        int e_lb;
        int g;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) model_reset_one(i);
            else        model_edge(i, fs, hit_v[i]);
        end
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            e_sp = (m_pulse[i] >= 0) ? (1 << m_pulse[i]) : 0;
            e_lb = 0;
            for (int l = 0; l < 3; l++) if (m_hold[i][l] != 0) e_lb |= (1 << l);
            chk($sformatf("cycle_dut%0d", i), int'({sp[i], lb[i], tot[i]}),
                (e_sp << 11) | (e_lb << 8) | m_total[i]);
        end
        if (sp[3] != 3'b000) begin
            if (hit_v[3]) pulses_after_hit++;
            if (last_pulse < 0) begin
                chk("first_spawn_frame", frame_no, 30);
            end else begin
                g = frame_no - last_pulse;
                n_tests++;
                if (g < 30 || g > 37) begin
                    n_fail++;
                    $display("FAIL gap_in_range: got %0d frames, required 30..37", g);
                end
            end
            last_pulse = frame_no;
        end
    endtask

    task automatic frame();
        frame_no++;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        bit   armed;
        int   exp_tot;

        n_tests          = 0;
        n_fail           = 0;
        frame_no         = 0;
        last_pulse       = -1;
        pulses_after_hit = 0;
        cyc              = 0;
        rst_n            = 1'b0;
        fs               = 1'b0;
        hit_v            = 4'b0000;
        model_reset_all();

        tbl[0] = '{1,   0,   1, 1, 1};
        tbl[1] = '{2,   1,   2, 2, 2};
        tbl[2] = '{3,   1,   3, 3, 3};
        tbl[3] = '{10,  5,   3, 3, 10};
        tbl[4] = '{100, 50,  3, 3, 100};
        tbl[5] = '{101, 50,  4, 3, 101};
        tbl[6] = '{103, 51,  6, 3, 103};
        tbl[7] = '{300, 150, 9, 3, 255};

        repeat (3) tick();
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset_state_dut%0d", i), int'({sp[i], lb[i], tot[i]}), 0);
        rst_n = 1'b1;

        // Reset asserted while dut3 sits in its lane-choice cycle.
        repeat (29) frame();
        frame_no++;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk("pre_reset_total_dut2", int'(tot[2]), 29);
        rst_n = 1'b0;
        #1;
        model_reset_all();
        for (int i = 0; i < 4; i++)
            chk($sformatf("async_reset_dut%0d", i), int'({sp[i], lb[i], tot[i]}), 0);
        tick();
        tick();
        rst_n      = 1'b1;
        frame_no   = 0;
        last_pulse = -1;

        for (int v = 0; v < 8; v++) begin
            while (frame_no < tbl[v].frames) frame();
            chk($sformatf("tbl%0d_total_dut0", v), int'(tot[0]), tbl[v].t0);
            chk($sformatf("tbl%0d_total_dut1", v), int'(tot[1]), tbl[v].t1);
            chk($sformatf("tbl%0d_busy_dut1", v), $countones(lb[1]), tbl[v].b1);
            chk($sformatf("tbl%0d_total_dut2", v), int'(tot[2]), tbl[v].t2);
        end

        while (frame_no < 2000) frame();
        chk("saturated_total_dut2", int'(tot[2]), 255);

        // Raise hit so it is sampled on dut3's firing edge.
        armed   = 1'b0;
        exp_tot = 0;
        for (int f = 0; f < 60 && !armed; f++) begin
            frame_no++;
            fs = 1'b1;
            tick();
            fs = 1'b0;
            if (m_pick_at[3] == cyc) begin
                armed = 1'b1;
                tick();
                hit_v[3] = 1'b1;
                exp_tot  = m_total[3];
                tick();
                chk("hit_on_fire_pulse", int'(sp[3]), 0);
                chk("hit_on_fire_total", int'(tot[3]), exp_tot);
                repeat (2) tick();
            end else begin
                repeat (4) tick();
            end
        end
        n_tests++;
        if (!armed) begin
            n_fail++;
            $display("FAIL hit_arm: got no spawn decision within 60 frames, required one");
        end
        repeat (50) frame();
        chk("no_pulse_after_hit", pulses_after_hit, 0);
        chk("frozen_total_after_hit", int'(tot[3]), exp_tot);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
